// File: rtl/imem_readback.sv
// Reads word_count 32-bit words from a byte-wide instruction RAM, one byte per
// cycle, and presents each reassembled big-endian word on a valid/ready port.
module imem_readback #(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-3:0] base_word,
   input  logic [CNT_W-1:0]  word_count,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DRAIN,
      OUT,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-3:0] word_ptr_q, word_ptr_d;
   logic [CNT_W-1:0]  remain_q, remain_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [31:0]       data_q, data_d;
   logic              cap_en;
   logic [1:0]        cap_idx;

   always_comb begin
      state_d    = state_q;
      word_ptr_d = word_ptr_q;
      remain_d   = remain_q;
      byte_idx_d = byte_idx_q;
      data_d     = data_q;
      cap_en     = 1'b0;
      cap_idx    = 2'd0;
      mem_en     = 1'b0;
      mem_addr   = '0;
      out_valid  = 1'b0;
      out_data   = '0;
      out_last   = 1'b0;
      busy       = (state_q != IDLE);
      done       = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (word_count == '0) begin
                  state_d = DONE;
               end else begin
                  word_ptr_d = base_word;
                  remain_d   = word_count;
                  byte_idx_d = 2'd0;
                  state_d    = FETCH;
               end
            end
         end
         FETCH: begin
            mem_en     = 1'b1;
            mem_addr   = {word_ptr_q, 2'b00} + ADDR_W'(byte_idx_q);
            byte_idx_d = byte_idx_q + 2'd1;
            // RAM answers one cycle late, so each cycle stores the previous byte
            cap_en     = (byte_idx_q != 2'd0);
            cap_idx    = byte_idx_q - 2'd1;
            if (byte_idx_q == 2'd3) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            cap_en  = 1'b1;
            cap_idx = 2'd3;
            state_d = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            out_data  = data_q;
            out_last  = (remain_q == CNT_W'(1));
            if (out_ready) begin
               if (remain_q == CNT_W'(1)) begin
                  state_d = DONE;
               end else begin
                  word_ptr_d = word_ptr_q + 1'b1;
                  remain_d   = remain_q - CNT_W'(1);
                  state_d    = FETCH;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (cap_en) begin
         case (cap_idx)
            2'd0:    data_d[31:24] = mem_rdata;
            2'd1:    data_d[23:16] = mem_rdata;
            2'd2:    data_d[15:8]  = mem_rdata;
            default: data_d[7:0]   = mem_rdata;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         word_ptr_q <= '0;
         remain_q   <= '0;
         byte_idx_q <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         word_ptr_q <= word_ptr_d;
         remain_q   <= remain_d;
         byte_idx_q <= byte_idx_d;
         data_q     <= data_d;
      end
   end

endmodule

// File: tb/tb_imem_readback.sv
// Self-checking bench for imem_readback: a wide (ADDR_W=10) and a narrow
// (ADDR_W=4) instance share one byte RAM model and a word-level reference.
module tb_imem_readback;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  base_word = '0;
   logic [7:0]  word_count = '0;
   logic        out_ready = 1'b0;
   bit          sel = 1'b0;

   logic        a_mem_en, a_out_valid, a_out_last, a_busy, a_done;
   logic [9:0]  a_mem_addr;
   logic [31:0] a_out_data;
   logic [7:0]  a_rdata = '0;
   logic        b_mem_en, b_out_valid, b_out_last, b_busy, b_done;
   logic [3:0]  b_mem_addr;
   logic [31:0] b_out_data;
   logic [7:0]  b_rdata = '0;

   logic        start_a, start_b;
   logic        obs_mem_en, obs_out_valid, obs_out_last, obs_busy, obs_done;
   logic [9:0]  obs_mem_addr;
   logic [31:0] obs_out_data;

   logic [7:0]  ram [0:1023];
   int          errors = 0;
   int          checks = 0;

   always #5 clock = ~clock;

   assign start_a = start && !sel;
   assign start_b = start && sel;

   imem_readback #(.ADDR_W(10), .CNT_W(8)) dut_a (
      .clock(clock), .reset(reset), .start(start_a), .base_word(base_word),
      .word_count(word_count), .mem_en(a_mem_en), .mem_addr(a_mem_addr),
      .mem_rdata(a_rdata), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_data(a_out_data), .out_last(a_out_last), .busy(a_busy), .done(a_done)
   );

   imem_readback #(.ADDR_W(4), .CNT_W(8)) dut_b (
      .clock(clock), .reset(reset), .start(start_b), .base_word(base_word[1:0]),
      .word_count(word_count), .mem_en(b_mem_en), .mem_addr(b_mem_addr),
      .mem_rdata(b_rdata), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy), .done(b_done)
   );

   assign obs_mem_en    = sel ? b_mem_en : a_mem_en;
   assign obs_mem_addr  = sel ? {6'd0, b_mem_addr} : a_mem_addr;
   assign obs_out_valid = sel ? b_out_valid : a_out_valid;
   assign obs_out_data  = sel ? b_out_data : a_out_data;
   assign obs_out_last  = sel ? b_out_last : a_out_last;
   assign obs_busy      = sel ? b_busy : a_busy;
   assign obs_done      = sel ? b_done : a_done;

   // RAM model: byte appears one cycle after the strobe
   always @(posedge clock) begin
      if (a_mem_en) a_rdata <= ram[a_mem_addr];
      if (b_mem_en) b_rdata <= ram[{6'd0, b_mem_addr}];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input bit use_b, input int w);
      int nwords = use_b ? 4 : 256;
      int idx = (w % nwords) * 4;
      return {ram[idx], ram[idx+1], ram[idx+2], ram[idx+3]};
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_en"}, obs_mem_en, 0);
      check({tag, "_mem_addr"}, obs_mem_addr, 0);
      check({tag, "_out_valid"}, obs_out_valid, 0);
      check({tag, "_out_data"}, obs_out_data, 0);
      check({tag, "_out_last"}, obs_out_last, 0);
      check({tag, "_busy"}, obs_busy, 0);
      check({tag, "_done"}, obs_done, 0);
   endtask

   // mode 0: ready always high, 1: 5-cycle stall on stall_word, 2: random ready
   task automatic run_request(input bit use_b, input int base, input int cnt,
                              input int mode, input int stall_word, input bit repulse);
      int          nwords = use_b ? 4 : 256;
      logic [9:0]  addr_q[$];
      int          word_i = 0;
      int          ref_edge = 1;
      int          last_hs = -1;
      int          stall_left = 0;
      bit          seen_valid = 1'b0;
      bit          done_seen = 1'b0;
      bit          rdy;
      for (int i = 0; i < cnt; i++)
         for (int b = 0; b < 4; b++)
            addr_q.push_back(10'(((base + i) % nwords) * 4 + b));
      sel        = use_b;
      base_word  = 8'(base);
      word_count = 8'(cnt);
      start      = 1'b1;
      out_ready  = (mode != 2);
      for (int k = 1; k <= cnt * 40 + 60 && !done_seen; k++) begin
         @(posedge clock);
         #1;
         start = 1'b0;
         if (repulse && (k == 3 || k == 6)) begin
            start     = 1'b1;
            base_word = 8'd2;
         end
         check("busy", obs_busy, 1);
         check("no_fetch_while_valid", obs_mem_en && obs_out_valid, 0);
         if (obs_mem_en) begin
            check("mem_en_expected", addr_q.size() != 0, 1);
            if (addr_q.size() != 0) check("mem_addr", obs_mem_addr, addr_q.pop_front());
         end
         if (obs_out_valid) begin
            check("valid_expected", word_i < cnt, 1);
            if (!seen_valid) begin
               check("first_valid_latency", k, ref_edge + 5);
               seen_valid = 1'b1;
               stall_left = (mode == 1 && word_i == stall_word) ? 5 : 0;
            end
            check("out_data", obs_out_data, model_word(use_b, base + word_i));
            check("out_last", obs_out_last, word_i == cnt - 1);
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) begin
               rdy = (stall_left == 0);
               if (stall_left > 0) stall_left--;
            end else rdy = ($urandom_range(0, 2) != 0);
            out_ready = rdy;
            if (rdy) begin
               word_i++;
               ref_edge   = k + 1;
               last_hs    = k + 1;
               seen_valid = 1'b0;
            end
         end else begin
            check("out_last_idle", obs_out_last, 0);
            out_ready = (mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
         end
         if (obs_done) begin
            done_seen = 1'b1;
            check("words_at_done", word_i, cnt);
            check("done_timing", k, (cnt == 0) ? 1 : last_hs);
            check("all_bytes_issued", addr_q.size(), 0);
         end
      end
      start = 1'b0;
      check("done_seen", done_seen, 1);
      @(posedge clock);
      #1;
      check("done_one_cycle", obs_done, 0);
      check("idle_after_done", obs_busy, 0);
   endtask

   initial begin
      logic [31:0] init_w [4];
      int          base_r, cnt_r;
      bit          use_b_r;
      init_w[0] = 32'h00000000;
      init_w[1] = 32'h00500093;
      init_w[2] = 32'h00500113;
      init_w[3] = 32'hFE208CE3;
      for (int i = 16; i < 1024; i++) ram[i] = 8'($urandom);
      for (int w = 0; w < 4; w++) begin
         ram[4*w]   = init_w[w][31:24];
         ram[4*w+1] = init_w[w][23:16];
         ram[4*w+2] = init_w[w][15:8];
         ram[4*w+3] = init_w[w][7:0];
      end

      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      sel = 1'b0;
      check_all_zero("reset_a");
      sel = 1'b1;
      check_all_zero("reset_b");
      reset = 1'b0;
      sel   = 1'b0;
      @(posedge clock);
      #1;

      $display("[TB] four-word readback, ready held high");
      run_request(1'b0, 0, 4, 0, 0, 1'b0);
      $display("[TB] same request with a stall on the third word");
      run_request(1'b0, 0, 4, 1, 2, 1'b0);
      $display("[TB] zero-length request");
      run_request(1'b0, 0, 0, 0, 0, 1'b0);
      $display("[TB] narrow instance address wrap");
      run_request(1'b1, 3, 2, 0, 0, 1'b0);

      $display("[TB] reset during fetch of the second word");
      sel        = 1'b0;
      base_word  = 8'd0;
      word_count = 8'd4;
      start      = 1'b1;
      out_ready  = 1'b1;
      repeat (8) begin
         @(posedge clock);
         #1;
         start = 1'b0;
      end
      check("in_fetch_before_reset", obs_mem_en, 1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check_all_zero("mid_reset");
      repeat (8) begin
         @(posedge clock);
         #1;
         check("post_reset_no_valid", obs_out_valid, 0);
         check("post_reset_no_done", obs_done, 0);
         check("post_reset_no_fetch", obs_mem_en, 0);
      end
      run_request(1'b0, 1, 1, 0, 0, 1'b0);

      $display("[TB] start re-pulsed while busy");
      run_request(1'b0, 0, 4, 0, 0, 1'b1);

      $display("[TB] randomized requests");
      for (int r = 0; r < 10; r++) begin
         use_b_r = ($urandom_range(0, 2) == 0);
         base_r  = use_b_r ? $urandom_range(0, 3) : $urandom_range(0, 255);
         cnt_r   = $urandom_range(0, 5);
         run_request(use_b_r, base_r, cnt_r, 2, 0, ($urandom_range(0, 1) == 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
